bus_enable_sequencer: RTL and testbench
=======================================

# bus_enable_sequencer

Sequential arbiter that owns the active-low output-enable vector for a shared tristate bus in the TTL simulation. It sits directly upstream of the tristate bus resolver: its `o_noe` vector drives the resolver's per-source enable inputs, and it reads back the resolver's combined enable to flag contention or a floating bus. It grants at most one source at a time in round-robin order, with break-before-make turnaround cycles between drivers.

## Interface
- `SOURCE_COUNT`, 4, number of bus sources (>= 2).
- `TURNAROUND`, 1, all-released cycles inserted between two grants (>= 1).
- `MAX_HOLD`, 0, max grant length in cycles while another source is requesting; 0 = unlimited.

- `i_clk` input 1: clock; all state changes on rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_req` input SOURCE_COUNT: per-source bus request, active high, level-sensitive.
- `i_bus_noe` input 1: resolver's combined enable; 0 = exactly one driver, 1 = none or several.
- `o_noe` output SOURCE_COUNT: registered active-low enables to the resolver; at most one bit 0.
- `o_grant_valid` output 1: registered; 1 while a source holds the bus.
- `o_grant_idx` output $clog2(SOURCE_COUNT): registered index of the current or last granted source.
- `o_contention` output 1: sticky error; set on a resolver/expectation mismatch, cleared only by reset.

## Operation
- Reset values (after the edge with `i_rst`=1):
  - `o_noe` = all ones; `o_grant_valid` = 0; `o_grant_idx` = 0; `o_contention` = 0.
  - State = IDLE; round-robin pointer = SOURCE_COUNT-1; hold and turn counters = 0.
- States:
  - IDLE: no driver.
  - GRANT: one driver.
  - TURN: no driver, counting turnaround.
- Round-robin selection:
  - Search `i_req` starting at pointer+1, wrapping modulo SOURCE_COUNT. The first set bit wins.
  - On grant, the pointer becomes the winner's index.
- IDLE:
  - Any `i_req` set: go to GRANT. `o_noe[k]`=0, `o_grant_valid`=1, `o_grant_idx`=k, hold counter=0.
  - Otherwise stay in IDLE.
- GRANT, voluntary release:
  - If `i_req[k]`=0: `o_noe` all ones, `o_grant_valid`=0, go to TURN with turn counter=TURNAROUND-1.
- GRANT, forced release:
  - Applies when MAX_HOLD>0, hold counter == MAX_HOLD-1, and any other `i_req` bit is set.
  - Behaves identically to a voluntary release.
- GRANT, otherwise: hold counter increments, saturating at MAX_HOLD-1; the grant is held.
- TURN:
  - Turn counter > 0: decrement it.
  - Turn counter == 0 with any request: grant directly per round-robin, same actions as IDLE.
  - Turn counter == 0 with no request: go to IDLE.
- A source never regains the bus in the same edge it releases it; it must wait through TURN.
- Contention check, evaluated at every edge not in reset:
  - Expected `i_bus_noe` = 0 when the registered `o_grant_valid`=1, else 1.
  - On a mismatch, `o_contention` is set to 1 and stays set.
  - The check is skipped in the first cycle after reset.
- Reset mid-grant: the next edge forces all reset values; the bus is released immediately, with no turnaround.
- `i_req` changes on non-granted bits never affect the current grant, except as the trigger for a MAX_HOLD preemption.

## Timing
- Request latency: `i_req[k]` sampled high at edge E in IDLE gives `o_noe[k]`=0 after E (1 cycle).
- Release latency: `i_req[k]` sampled low at edge E in GRANT gives `o_noe` all ones after E.
- Handover gap between two drivers: exactly TURNAROUND cycles with `o_noe` all ones, provided the next request is present.
- Bounded hold: with MAX_HOLD=M>0 and a competing request, a grant lasts at most M cycles.
- Outputs are all registered. The only combinational path from input to output is none; `i_bus_noe` is sampled only.

## Test plan
- **Reset:** hold `i_rst`=1 for 2 cycles with `i_req`=4'b1111. Expect `o_noe`=4'b1111, `o_grant_valid`=0, `o_contention`=0.
- **Round-robin:** `i_req`=4'b1010 held, each grant released after 3 cycles by dropping that source's request, then reasserting it.
  - Expect grant order 1, 3, 1, 3.
  - With TURNAROUND=1, expect exactly 1 all-ones cycle between each pair of grants.
- **Turnaround:** TURNAROUND=3; source 0 releases while source 2 is requesting. Expect `o_noe`=4'b1111 for 3 cycles, then 4'b1011.
- **Preemption:** MAX_HOLD=4; source 0 holds its request; source 1 requests at cycle 1 of the grant. Expect source 0's grant to end after 4 cycles, followed by the turnaround, then `o_grant_idx`=1.
- **Contention:** in GRANT, force `i_bus_noe`=1 for 1 cycle. Expect `o_contention`=1 from the next edge and held until `i_rst`.
- **Reset mid-grant:** assert `i_rst` while source 2 is granted. Expect `o_noe`=4'b1111 after the next edge; the first grant after reset goes to the lowest requesting index.

Source files
------------

// File: rtl/bus_enable_sequencer.sv
// Round-robin owner of the active-low enable vector for a shared tristate bus.
// It grants one source at a time, with break-before-make turnaround, and flags resolver disagreement.
module bus_enable_sequencer #(
  parameter int SOURCE_COUNT = 4,
  parameter int TURNAROUND   = 1,
  parameter int MAX_HOLD     = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [SOURCE_COUNT-1:0]         i_req,
  input  logic                            i_bus_noe,
  output logic [SOURCE_COUNT-1:0]         o_noe,
  output logic                            o_grant_valid,
  output logic [$clog2(SOURCE_COUNT)-1:0] o_grant_idx,
  output logic                            o_contention
);

  localparam int IW = $clog2(SOURCE_COUNT);
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [IW-1:0] PTR_RST   = IW'(SOURCE_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_TURN
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [SOURCE_COUNT-1:0] r_noe, w_noe_nxt;
  logic                    r_valid, w_valid_nxt;
  logic [IW-1:0]           r_idx, w_idx_nxt;
  logic [IW-1:0]           r_ptr, w_ptr_nxt;
  logic [HW-1:0]           r_hold, w_hold_nxt;
  logic [TW-1:0]           r_turn, w_turn_nxt;
  logic                    r_contention;
  logic                    r_chk_en;

  logic                    w_found;
  logic [IW-1:0]           w_win;
  logic [IW-1:0]           w_cand;
  logic [SOURCE_COUNT-1:0] w_own;
  logic                    w_other;
  logic                    w_force;
  logic                    w_do_grant;
  logic                    w_do_release;

  // First requester strictly after the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int i = 1; i <= SOURCE_COUNT; i++) begin
      w_cand = IW'((int'(r_ptr) + i) % SOURCE_COUNT);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_own        = '0;
    w_own[r_idx] = 1'b1;
    w_other      = |(i_req & ~w_own);
    w_force      = (MAX_HOLD > 0) && (r_hold == HOLD_LAST) && w_other;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_noe_nxt    = r_noe;
    w_valid_nxt  = r_valid;
    w_idx_nxt    = r_idx;
    w_ptr_nxt    = r_ptr;
    w_hold_nxt   = r_hold;
    w_turn_nxt   = r_turn;
    w_do_grant   = 1'b0;
    w_do_release = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) w_do_grant = 1'b1;
      end
      S_GRANT: begin
        if (!i_req[r_idx] || w_force) begin
          w_do_release = 1'b1;
        end else if (r_hold != HOLD_LAST) begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      S_TURN: begin
        if (r_turn != '0) begin
          w_turn_nxt = r_turn - TW'(1);
        end else if (w_found) begin
          w_do_grant = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_noe_nxt   = '1;
        w_valid_nxt = 1'b0;
      end
    endcase

    // Releasing always lands in TURN, so the releasing source cannot win on the same edge.
    if (w_do_release) begin
      w_state_nxt = S_TURN;
      w_noe_nxt   = '1;
      w_valid_nxt = 1'b0;
      w_turn_nxt  = TURN_LAST;
    end

    if (w_do_grant) begin
      w_state_nxt        = S_GRANT;
      w_noe_nxt          = '1;
      w_noe_nxt[w_win]   = 1'b0;
      w_valid_nxt        = 1'b1;
      w_idx_nxt          = w_win;
      w_ptr_nxt          = w_win;
      w_hold_nxt         = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_noe   <= '1;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= PTR_RST;
      r_hold  <= '0;
      r_turn  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_noe   <= w_noe_nxt;
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_turn  <= w_turn_nxt;
    end
  end

  // Resolver must report exactly one driver while we grant, none otherwise.
  // The first edge out of reset is skipped so the resolver can settle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_contention <= 1'b0;
      r_chk_en     <= 1'b0;
    end else begin
      r_chk_en <= 1'b1;
      if (r_chk_en && (i_bus_noe != !r_valid)) r_contention <= 1'b1;
    end
  end

  assign o_noe         = r_noe;
  assign o_grant_valid = r_valid;
  assign o_grant_idx   = r_idx;
  assign o_contention  = r_contention;

endmodule

// File: tb/tb_bus_enable_sequencer.sv
// Bench for bus_enable_sequencer: two instances (TURNAROUND=1/MAX_HOLD=0 and TURNAROUND=3/MAX_HOLD=4)
// checked every cycle against an ownership-level model, plus directed literal expectations.
module tb_bus_enable_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req_a, req_b;
  logic       inj_a, inj_b;
  logic [3:0] noe_a, noe_b;
  logic       gv_a, gv_b;
  logic [1:0] gi_a, gi_b;
  logic       ct_a, ct_b;
  logic       bn_a, bn_b;

  // Resolver stand-in: low only when exactly one enable is active; inj flips it to fake a fault.
  assign bn_a = (($countones(~noe_a) == 1) ? 1'b0 : 1'b1) ^ inj_a;
  assign bn_b = (($countones(~noe_b) == 1) ? 1'b0 : 1'b1) ^ inj_b;

  bus_enable_sequencer #(.SOURCE_COUNT(4), .TURNAROUND(1), .MAX_HOLD(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_bus_noe(bn_a),
    .o_noe(noe_a), .o_grant_valid(gv_a), .o_grant_idx(gi_a), .o_contention(ct_a));

  bus_enable_sequencer #(.SOURCE_COUNT(4), .TURNAROUND(3), .MAX_HOLD(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_bus_noe(bn_b),
    .o_noe(noe_b), .o_grant_valid(gv_b), .o_grant_idx(gi_b), .o_contention(ct_b));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: who owns the bus, how long they have held it, idle cycles left before the next grant.
  int m_owner[2], m_held[2], m_gap[2], m_last[2], m_idx[2];
  bit m_cont[2], m_first[2], m_live[2];
  int TA[2] = '{1, 3};
  int MH[2] = '{0, 4};

  task automatic model_step(input int j, input logic [3:0] r, input logic rs, input logic inj);
    logic [3:0] others;
    int w;
    if (rs) begin
      m_owner[j] = -1; m_held[j] = 0; m_gap[j] = 0; m_last[j] = 3; m_idx[j] = 0;
      m_cont[j] = 0; m_first[j] = 1; m_live[j] = 1;
      return;
    end
    // A healthy resolver always agrees with us, so only an injected fault can disagree.
    if (!m_first[j] && inj) m_cont[j] = 1;
    m_first[j] = 0;
    if (m_owner[j] >= 0) begin
      others = r;
      others[m_owner[j]] = 1'b0;
      if (!r[m_owner[j]] || (MH[j] > 0 && m_held[j] + 1 >= MH[j] && others != 0)) begin
        m_owner[j] = -1;
        m_gap[j]   = TA[j];
      end else begin
        m_held[j]++;
      end
    end else if (m_gap[j] > 1) begin
      m_gap[j]--;
    end else begin
      m_gap[j] = 0;
      w = -1;
      for (int i = 1; i <= 4; i++)
        if (w < 0 && r[(m_last[j] + i) % 4]) w = (m_last[j] + i) % 4;
      if (w >= 0) begin
        m_owner[j] = w; m_held[j] = 0; m_idx[j] = w; m_last[j] = w;
      end
    end
  endtask

  function automatic int exp_noe(input int o);
    logic [3:0] v;
    v = 4'hf;
    if (o >= 0) v[o] = 1'b0;
    return int'(v);
  endfunction

  initial begin
    m_live[0] = 0;
    m_live[1] = 0;
    forever begin
      @(posedge clk);
      model_step(0, req_a, rst, inj_a);
      model_step(1, req_b, rst, inj_b);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (m_live[0]) begin
        chk("a_noe",   int'(noe_a), exp_noe(m_owner[0]));
        chk("a_valid", int'(gv_a),  int'(m_owner[0] >= 0));
        chk("a_idx",   int'(gi_a),  m_idx[0]);
        chk("a_cont",  int'(ct_a),  int'(m_cont[0]));
      end
      if (m_live[1]) begin
        chk("b_noe",   int'(noe_b), exp_noe(m_owner[1]));
        chk("b_valid", int'(gv_b),  int'(m_owner[1] >= 0));
        chk("b_idx",   int'(gi_b),  m_idx[1]);
        chk("b_cont",  int'(ct_b),  int'(m_cont[1]));
      end
    end
  end

  initial begin
    int order[4] = '{1, 3, 1, 3};
    int gap, held;
    bit got;

    rst = 1'b1; req_a = 4'b1111; req_b = 4'b1111; inj_a = 1'b0; inj_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_noe",   int'(noe_a), 4'hf);
    chk("rst_valid", int'(gv_a),  0);
    chk("rst_cont",  int'(ct_a),  0);
    chk("rst_noe_b", int'(noe_b), 4'hf);
    rst = 1'b0; req_a = 4'b0000; req_b = 4'b0000;
    repeat (2) @(negedge clk);

    // Round robin 1,3,1,3 with a single all-ones cycle between grants.
    req_a = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 10; t++) begin
        if (gv_a) break;
        @(negedge clk);
      end
      got = gv_a;
      chk("rr_wait", int'(got), 1);
      chk("rr_order", int'(gi_a), order[k]);
      chk("rr_model_pin", m_idx[0], order[k]);
      repeat (2) @(negedge clk);
      req_a[order[k]] = 1'b0;
      gap = 0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (gv_a) break;
        chk("rr_gap_noe", int'(noe_a), 4'hf);
        gap++;
        req_a = 4'b1010;
      end
      chk("rr_gap", gap, 1);
    end
    req_a = 4'b0000;
    repeat (4) @(negedge clk);

    // Turnaround of 3 on instance B: source 0 releases while source 2 waits.
    req_b = 4'b0001;
    @(negedge clk);
    chk("turn_first", int'(noe_b), 4'b1110);
    req_b = 4'b0100;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("turn_gap", int'(noe_b), 4'hf);
    end
    @(negedge clk);
    chk("turn_next", int'(noe_b), 4'b1011);
    req_b = 4'b0000;
    repeat (6) @(negedge clk);

    // Preemption: MAX_HOLD=4, source 1 competes from grant cycle 1.
    req_b = 4'b0001;
    @(negedge clk);
    chk("pre_grant0", int'(gv_b && gi_b == 2'd0), 1);
    req_b = 4'b0011;
    held = 1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (!(gv_b && gi_b == 2'd0)) break;
      held++;
    end
    chk("pre_hold_len", held, 4);
    gap = 1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (gv_b) break;
      gap++;
    end
    chk("pre_gap", gap, 3);
    chk("pre_idx", int'(gi_b), 1);
    chk("pre_noe", int'(noe_b), 4'b1101);
    req_b = 4'b0000;
    repeat (6) @(negedge clk);

    // Contention: one-cycle resolver disagreement during a grant is sticky.
    req_a = 4'b0100;
    @(negedge clk);
    chk("cont_grant", int'(noe_a), 4'b1011);
    inj_a = 1'b1;
    @(negedge clk);
    inj_a = 1'b0;
    chk("cont_set", int'(ct_a), 1);
    repeat (3) @(negedge clk);
    chk("cont_hold", int'(ct_a), 1);
    chk("cont_b_clean", int'(ct_b), 0);

    // Reset while source 2 holds the bus; lowest requester wins afterwards.
    req_a = 4'b0110;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_noe",  int'(noe_a), 4'hf);
    chk("mid_rst_cont", int'(ct_a), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idx", int'(gi_a), 1);
    chk("post_rst_noe", int'(noe_a), 4'b1101);
    req_a = 4'b0000;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
